mouse_ps2_receiver: RTL and testbench

//  PS/2 device-to-host byte receiver; directly upstream of the mouse master state machine.

---
 rtl/mouse_ps2_pkg.sv | 27 ++
 rtl/ps2_line_sync.sv | 39 +++
 rtl/mouse_ps2_receiver.sv | 126 ++++++++++++
 tb/tb_mouse_ps2_receiver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mouse_ps2_pkg.sv
// Shared PS/2 mouse definitions: receiver state encoding, error codes and protocol bytes.
// Used by the receiver and by the master/transmitter side.
package mouse_ps2_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_DONE
    } rx_state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    localparam logic [7:0] CMD_RESET        = 8'hFF;
    localparam logic [7:0] CMD_ENABLE_REP   = 8'hF4;
    localparam logic [7:0] RSP_ACK          = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST_OK  = 8'hAA;

    // Odd parity over data+parity bit; stop bit must be 1.
    function automatic logic [1:0] frame_err(input logic [7:0] dat, input logic par, input logic stp);
        return {~stp, ~(^{dat, par})};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the PS/2 clock and data lines and emits a registered falling-edge strobe
// with the data level captured in the same cycle. Latency: SYNC_STAGES+1 cycles. No backpressure.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic dat_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall_q;
    logic                   dat_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            dat_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            fall_q     <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            dat_q      <= dat_sync_q[SYNC_STAGES-1];
        end
    end

    assign dat_o  = dat_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/mouse_ps2_receiver.sv
// PS/2 device-to-host byte receiver: deframes 11-bit frames, strobes BYTE_READY for one cycle per frame.
// Latency: strobe a few cycles after the stop-bit falling edge. Gated by READ_ENABLE; optional MOUSE_RX_WATCHDOG_EN.
module mouse_ps2_receiver
    import mouse_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    rx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       par_q, par_d;
    logic       stop_q, stop_d;
    logic [7:0] byte_q, byte_d;
    logic [1:0] err_q, err_d;
    logic       rdy_q, rdy_d;
    logic       fall, dat;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i    (CLK),
        .rst_n_i  (RESET_N),
        .ps2_clk_i(CLK_MOUSE_IN),
        .ps2_dat_i(DATA_MOUSE_IN),
        .dat_o    (dat),
        .fall_o   (fall)
    );

`ifdef MOUSE_RX_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expired;

    assign wd_d       = (fall || state_q == RX_IDLE) ? '0 : wd_q + 1'b1;
    assign wd_expired = (state_q == RX_DATA || state_q == RX_PARITY || state_q == RX_STOP)
                        && !fall && (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) wd_q <= '0;
        else          wd_q <= wd_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        stop_d    = stop_q;
        byte_d    = byte_q;
        err_d     = err_q;
        rdy_d     = 1'b0;
        if (!READ_ENABLE) begin
            // Master abandoned the transfer: drop any partial frame and present a clean code.
            state_d = RX_IDLE;
            err_d   = ERR_NONE;
        end else begin
            unique case (state_q)
                RX_IDLE: if (fall && !dat) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
                RX_DATA: if (fall) begin
                    shift_d[bit_cnt_q] = dat;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: if (fall) begin
                    par_d   = dat;
                    state_d = RX_STOP;
                end
                RX_STOP: if (fall) begin
                    stop_d  = dat;
                    state_d = RX_DONE;
                end
                RX_DONE: begin
                    byte_d  = shift_q;
                    err_d   = frame_err(shift_q, par_q, stop_q);
                    rdy_d   = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
`ifdef MOUSE_RX_WATCHDOG_EN
            if (wd_expired) state_d = RX_IDLE;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= RX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            byte_q    <= '0;
            err_q     <= ERR_NONE;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = rdy_q;

endmodule

// File: tb/tb_mouse_ps2_receiver.sv
// Directed bench for mouse_ps2_receiver; the watchdog step runs only when MOUSE_RX_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_mouse_ps2_receiver;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       CLK_MOUSE_IN = 1'b1;
    logic       DATA_MOUSE_IN = 1'b1;
    logic       READ_ENABLE = 1'b0;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    int         checks = 0;
    int         errors = 0;
    int         strobes = 0;
    int         base;
    logic [7:0] cap_byte = 8'h00;
    logic [1:0] cap_code = 2'b00;

    mouse_ps2_receiver #(.TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .CLK_MOUSE_IN   (CLK_MOUSE_IN),
        .DATA_MOUSE_IN  (DATA_MOUSE_IN),
        .READ_ENABLE    (READ_ENABLE),
        .BYTE_READ      (BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY     (BYTE_READY)
    );

    always #5 CLK = ~CLK;

    // Every high cycle counts, so a stretched strobe shows up as extra strobes.
    always @(negedge CLK) begin
        if (BYTE_READY === 1'b1) begin
            strobes++;
            cap_byte = BYTE_READ;
            cap_code = BYTE_ERROR_CODE;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        DATA_MOUSE_IN = b;
        cycles(10);
        CLK_MOUSE_IN = 1'b0;
        cycles(10);
        CLK_MOUSE_IN = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) send_bit(frame[i]);
        DATA_MOUSE_IN = 1'b1;
    endtask

    // Frame bits LSB first: start, data[0..7], parity, stop.
    function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bits(mk(d, par, stp), 11);
        cycles(20);
    endtask

    initial begin
        cycles(3);
        check("reset_byte",  32'(BYTE_READ), 32'h00);
        check("reset_code",  32'(BYTE_ERROR_CODE), 32'h0);
        check("reset_ready", 32'(BYTE_READY), 32'h0);
        RESET_N = 1'b1;
        READ_ENABLE = 1'b1;
        cycles(5);

        // 0xFA: six ones, odd parity bit 1, clean
        send_frame(8'hFA, 1'b1, 1'b1);
        check("fa_strobes", 32'(strobes), 32'd1);
        check("fa_byte",    32'(cap_byte), 32'hFA);
        check("fa_code",    32'(cap_code), 32'h0);
        check("fa_hold",    32'(BYTE_READ), 32'hFA);

        // 0xAA: four ones needs parity 1; sending 0 is a parity error
        send_frame(8'hAA, 1'b0, 1'b1);
        check("aa_strobes", 32'(strobes), 32'd2);
        check("aa_byte",    32'(cap_byte), 32'hAA);
        check("aa_code",    32'(cap_code), 32'h1);

        // 0x08: one 1, parity 0 correct, stop bit 0
        send_frame(8'h08, 1'b0, 1'b0);
        check("stop_strobes", 32'(strobes), 32'd3);
        check("stop_byte",    32'(cap_byte), 32'h08);
        check("stop_code",    32'(BYTE_ERROR_CODE), 32'h2);
        READ_ENABLE = 1'b0;
        cycles(1);
        READ_ENABLE = 1'b1;
        cycles(1);
        check("re_low_code", 32'(BYTE_ERROR_CODE), 32'h0);
        check("re_low_byte", 32'(BYTE_READ), 32'h08);

        // Abort after four data bits; the tail of that frame arrives while disabled
        base = strobes;
        send_bits(mk(8'h35, 1'b1, 1'b1), 5);
        READ_ENABLE = 1'b0;
        send_bits(mk(8'h35, 1'b1, 1'b1) >> 5, 6);
        cycles(20);
        check("abort_no_strobe", 32'(strobes), 32'(base));
        READ_ENABLE = 1'b1;
        cycles(5);
        send_frame(8'h00, 1'b1, 1'b1);
        check("after_abort_strobes", 32'(strobes), 32'(base + 1));
        check("after_abort_byte",    32'(cap_byte), 32'h00);
        check("after_abort_code",    32'(cap_code), 32'h0);

`ifdef MOUSE_RX_WATCHDOG_EN
        base = strobes;
        send_bits(mk(8'h5C, 1'b1, 1'b1), 6);
        cycles(1100);
        check("wd_no_strobe", 32'(strobes), 32'(base));
`endif

        // 0x28: two ones, parity 1
        base = strobes;
        send_frame(8'h28, 1'b1, 1'b1);
        check("x28_strobes", 32'(strobes), 32'(base + 1));
        check("x28_byte",    32'(cap_byte), 32'h28);
        check("x28_code",    32'(cap_code), 32'h0);

        // Asynchronous reset in the middle of a frame
        base = strobes;
        send_bits(mk(8'hC3, 1'b0, 1'b0), 4);
        cycles(3);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_byte",  32'(BYTE_READ), 32'h00);
        check("arst_code",  32'(BYTE_ERROR_CODE), 32'h0);
        check("arst_ready", 32'(BYTE_READY), 32'h0);
        cycles(2);
        RESET_N = 1'b1;
        cycles(60);
        check("arst_no_strobe", 32'(strobes), 32'(base));

        send_frame(8'hFA, 1'b1, 1'b1);
        check("recover_strobes", 32'(strobes), 32'(base + 1));
        check("recover_byte",    32'(cap_byte), 32'hFA);
        check("recover_code",    32'(cap_code), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
